// File: rtl/fft_arb_pkg.sv
// Shared types and constants for the FFT stream arbiter.
// No logic: enum, default sizes and channel-ID width only.
// No backpressure (package).
package fft_arb_pkg;

    // Frame-feed state: IDLE arbitrates, FEED streams the granted channel.
    typedef enum logic {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

    // Default samples per FFT frame.
    localparam int FRAME_LEN_DEF = 16;

    // Default number of frames that may be in flight inside the core.
    localparam int TAG_DEPTH_DEF = 4;

    // Width of a requester channel ID (two requesters).
    localparam int CHAN_W = 1;

endpackage

// File: rtl/fft_tag_fifo.sv
// Owner-tag FIFO: records which channel owns each frame in flight in the core.
// Latency: a pushed entry is visible at head one cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module fft_tag_fifo
    import fft_arb_pkg::*;
#(
    parameter int DEPTH = TAG_DEPTH_DEF,
    parameter int W     = CHAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fft_stream_arb.sv
// Two-requester FFT frame arbiter: grants whole frames to the core, tags results with their owner.
// Latency: input path combinational while granted; result path registered, exactly 1 cycle.
// Backpressure: core_stall forwarded to the granted channel only; out_stall passed straight to the core.
// Optional macro FFT_ARB_RR_EN: round-robin on simultaneous requests (default build: ch0 fixed priority).
module fft_stream_arb
    import fft_arb_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch0_push,
    input  logic [15:0] ch0_real,
    input  logic [15:0] ch0_imag,
    output logic        ch0_stall,
    input  logic        ch1_push,
    input  logic [15:0] ch1_real,
    input  logic [15:0] ch1_imag,
    output logic        ch1_stall,
    output logic        core_push,
    output logic [15:0] core_real,
    output logic [15:0] core_imag,
    input  logic        core_stall,
    input  logic        core_out_push,
    input  logic [15:0] core_out_real,
    input  logic [15:0] core_out_imag,
    output logic        core_out_stall,
    output logic        out_push_F,
    output logic [15:0] out_real_F,
    output logic [15:0] out_imag_F,
    output logic        out_chan_F,
    input  logic        out_stall,
    output logic        err_F
);

    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    state_t      state_q;
    state_t      state_d;
    logic        gnt_ch_q;
    logic        grant;
    logic        grant_ch;
    logic        pick_ch;
    logic        accept;
    logic        frame_done;
    logic [CW-1:0] samp_cnt_q;
    logic [CW-1:0] beat_cnt_q;
    logic        gnt_push;
    logic [15:0] gnt_real;
    logic [15:0] gnt_imag;
    logic        tag_pop;
    logic        tag_head;
    logic        tag_full;
    logic        tag_empty;

`ifdef FFT_ARB_RR_EN
    logic        last_gnt_q;

    // Tie goes to the channel that did not win last time.
    always_comb begin
        pick_ch = ch1_push;
        if (ch0_push && ch1_push) begin
            pick_ch = ~last_gnt_q;
        end
    end

    // Remember the most recent winner; reset value makes ch0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else if (grant) begin
            last_gnt_q <= grant_ch;
        end
    end
`else
    // Fixed priority: ch1 only wins when ch0 is not requesting.
    always_comb begin
        pick_ch = !ch0_push;
    end
`endif

    assign gnt_push = gnt_ch_q ? ch1_push : ch0_push;
    assign gnt_real = gnt_ch_q ? ch1_real : ch0_real;
    assign gnt_imag = gnt_ch_q ? ch1_imag : ch0_imag;

    // Next state, grant decision and routing of the granted channel to the core.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_ch   = 1'b0;
        accept     = 1'b0;
        frame_done = 1'b0;
        core_push  = 1'b0;
        core_real  = '0;
        core_imag  = '0;
        ch0_stall  = 1'b1;
        ch1_stall  = 1'b1;
        case (state_q)
            IDLE: begin
                if ((ch0_push || ch1_push) && !tag_full) begin
                    grant    = 1'b1;
                    grant_ch = pick_ch;
                    state_d  = FEED;
                end
            end
            FEED: begin
                core_push = gnt_push;
                core_real = gnt_real;
                core_imag = gnt_imag;
                if (gnt_ch_q) begin
                    ch1_stall = core_stall;
                end else begin
                    ch0_stall = core_stall;
                end
                accept = gnt_push && !core_stall;
                if (accept && (samp_cnt_q == CNT_LAST)) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset is synchronous, so the state may still read FEED this cycle.
        if (reset) begin
            grant     = 1'b0;
            core_push = 1'b0;
            ch0_stall = 1'b1;
            ch1_stall = 1'b1;
        end
    end

    // State, granted owner and accepted-sample counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_ch_q   <= 1'b0;
            samp_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                gnt_ch_q <= grant_ch;
            end
            if (frame_done) begin
                samp_cnt_q <= '0;
            end else if (accept) begin
                samp_cnt_q <= samp_cnt_q + 1'b1;
            end
        end
    end

    fft_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (CHAN_W)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (grant),
        .push_dat (grant_ch),
        .pop      (tag_pop),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    assign core_out_stall = out_stall;
    assign tag_pop        = core_out_push && (beat_cnt_q == CNT_LAST);

    // Result beat counter; wraps at the end of each returned frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else if (core_out_push) begin
            beat_cnt_q <= (beat_cnt_q == CNT_LAST) ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // Result register: one-cycle copy of the core output tagged with its owner.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_push_F <= 1'b0;
            out_real_F <= '0;
            out_imag_F <= '0;
            out_chan_F <= 1'b0;
            err_F      <= 1'b0;
        end else begin
            out_push_F <= core_out_push;
            if (core_out_push) begin
                out_real_F <= core_out_real;
                out_imag_F <= core_out_imag;
                out_chan_F <= tag_empty ? 1'b0 : tag_head;
                if (tag_empty) begin
                    err_F <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_stream_arb.sv
// Directed bench for fft_stream_arb: frame feed, arbitration, result tagging, reset.
// Latency: result outputs checked one cycle after the beat is driven.
// Backpressure: exercises core_stall mid-frame, tag-FIFO-full stall and out_stall pass-through.
module tb_fft_stream_arb;

`ifdef FFT_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ch0_push, ch1_push;
    logic [15:0] ch0_real, ch0_imag, ch1_real, ch1_imag;
    logic        ch0_stall, ch1_stall;
    logic        core_push;
    logic [15:0] core_real, core_imag;
    logic        core_stall;
    logic        core_out_push;
    logic [15:0] core_out_real, core_out_imag;
    logic        core_out_stall;
    logic        out_push_F;
    logic [15:0] out_real_F, out_imag_F;
    logic        out_chan_F;
    logic        out_stall;
    logic        err_F;

    int checks = 0;
    int errors = 0;

    fft_stream_arb #(
        .FRAME_LEN (16),
        .TAG_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ch0_push       (ch0_push),
        .ch0_real       (ch0_real),
        .ch0_imag       (ch0_imag),
        .ch0_stall      (ch0_stall),
        .ch1_push       (ch1_push),
        .ch1_real       (ch1_real),
        .ch1_imag       (ch1_imag),
        .ch1_stall      (ch1_stall),
        .core_push      (core_push),
        .core_real      (core_real),
        .core_imag      (core_imag),
        .core_stall     (core_stall),
        .core_out_push  (core_out_push),
        .core_out_real  (core_out_real),
        .core_out_imag  (core_out_imag),
        .core_out_stall (core_out_stall),
        .out_push_F     (out_push_F),
        .out_real_F     (out_real_F),
        .out_imag_F     (out_imag_F),
        .out_chan_F     (out_chan_F),
        .out_stall      (out_stall),
        .err_F          (err_F)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Starts in IDLE with requests already driven; checks the single IDLE
    // cycle, then 16 accepted samples from exp_ch. Both channels carry
    // distinct data so a wrong grant shows up on core_real/core_imag.
    task automatic run_frame(input logic exp_ch, input int stall_at);
        @(negedge clk);
        chk("idle_core_push", core_push, 0);
        chk("idle_ch0_stall", ch0_stall, 1);
        chk("idle_ch1_stall", ch1_stall, 1);
        nxt();
        for (int i = 0; i < 16; i++) begin
            ch0_real = 16'h0000 + 16'(i);
            ch0_imag = 16'h0800 + 16'(i);
            ch1_real = 16'h1000 + 16'(i);
            ch1_imag = 16'h1800 + 16'(i);
            if (i == stall_at) begin
                for (int s = 0; s < 2; s++) begin
                    core_stall = 1'b1;
                    @(negedge clk);
                    chk("stall_core_push", core_push, 1);
                    chk("stall_gnt_stall", exp_ch ? ch1_stall : ch0_stall, 1);
                    nxt();
                end
                core_stall = 1'b0;
            end
            @(negedge clk);
            chk("feed_core_push", core_push, 1);
            chk("feed_core_real", core_real, exp_ch ? 16'h1000 + 16'(i) : 16'(i));
            chk("feed_core_imag", core_imag, exp_ch ? 16'h1800 + 16'(i) : 16'h0800 + 16'(i));
            chk("feed_gnt_stall", exp_ch ? ch1_stall : ch0_stall, 0);
            chk("feed_other_stall", exp_ch ? ch0_stall : ch1_stall, 1);
            nxt();
        end
    endtask

    // Drives one 16-beat result frame; occ is the tag occupancy before it.
    task automatic return_frame(input logic exp_ch, input int occ);
        for (int j = 0; j < 16; j++) begin
            core_out_push = 1'b1;
            core_out_real = 16'h2000 + 16'(j);
            core_out_imag = 16'h3000 + 16'(j);
            nxt();
            chk("res_push", out_push_F, 1);
            chk("res_real", out_real_F, 16'h2000 + 16'(j));
            chk("res_imag", out_imag_F, 16'h3000 + 16'(j));
            chk("res_chan", out_chan_F, exp_ch);
            if (j == 14) chk("tag_occ_before_pop", dut.u_tag_fifo.count, occ);
            if (j == 15) chk("tag_occ_after_pop", dut.u_tag_fifo.count, occ - 1);
        end
        core_out_push = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ch0_push = 1'b1; ch1_push = 1'b0;
        ch0_real = '0; ch0_imag = '0; ch1_real = '0; ch1_imag = '0;
        core_stall = 1'b0; core_out_push = 1'b0;
        core_out_real = '0; core_out_imag = '0; out_stall = 1'b0;

        // Outputs held quiet while reset is asserted, even with a request.
        @(negedge clk);
        chk("rst_ch0_stall", ch0_stall, 1);
        chk("rst_ch1_stall", ch1_stall, 1);
        chk("rst_core_push", core_push, 0);
        nxt();
        reset = 1'b0;
        ch0_push = 1'b0;
        @(negedge clk);
        chk("rst_out_push", out_push_F, 0);
        chk("rst_out_real", out_real_F, 0);
        chk("rst_out_imag", out_imag_F, 0);
        chk("rst_out_chan", out_chan_F, 0);
        chk("rst_err", err_F, 0);
        chk("rst_tag_empty", dut.u_tag_fifo.empty, 1);
        nxt();

        // out_stall reaches the core combinationally.
        out_stall = 1'b1;
        #1 chk("core_out_stall_hi", core_out_stall, 1);
        out_stall = 1'b0;
        #1 chk("core_out_stall_lo", core_out_stall, 0);

        // ch0 alone, one frame, with a two-cycle core stall at sample 3.
        ch0_push = 1'b1;
        run_frame(1'b0, 3);
        ch0_push = 1'b0;
        @(negedge clk);
        chk("a_done_core_push", core_push, 0);
        chk("a_tag_occ", dut.u_tag_fifo.count, 1);
        chk("a_tag_head", dut.u_tag_fifo.head, 0);
        nxt();
        return_frame(1'b0, 1);
        nxt();
        chk("a_out_push_idle", out_push_F, 0);
        chk("a_err", err_F, 0);

        // ch1 alone: results carry owner 1 and the tag pops on beat 16.
        ch1_push = 1'b1;
        run_frame(1'b1, -1);
        ch1_push = 1'b0;
        nxt();
        return_frame(1'b1, 1);
        nxt();

        // Both request continuously: four frames fill the tag FIFO.
        ch0_push = 1'b1;
        ch1_push = 1'b1;
        run_frame(1'b0, -1);
        run_frame(RR, -1);
        run_frame(1'b0, -1);
        run_frame(RR, -1);

        // Tag FIFO full: fifth request must wait in IDLE.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_core_push", core_push, 0);
            chk("full_ch0_stall", ch0_stall, 1);
            chk("full_ch1_stall", ch1_stall, 1);
            chk("full_flag", dut.u_tag_fifo.full, 1);
            nxt();
        end
        // First result frame frees a slot; grant follows in the next cycle.
        return_frame(1'b0, 4);
        run_frame(1'b0, -1);
        ch0_push = 1'b0;
        ch1_push = 1'b0;
        return_frame(RR, 4);
        return_frame(1'b0, 3);

        // Reset during sample 7 of a ch0 frame, with two frames pending.
        ch0_push = 1'b1;
        nxt();
        for (int i = 0; i < 7; i++) begin
            ch0_real = 16'(i);
            nxt();
        end
        reset = 1'b1;
        core_out_push = 1'b1;
        @(negedge clk);
        chk("midrst_ch0_stall", ch0_stall, 1);
        chk("midrst_core_push", core_push, 0);
        nxt();
        reset = 1'b0;
        ch0_push = 1'b0;
        core_out_push = 1'b0;
        @(negedge clk);
        chk("postrst_out_push", out_push_F, 0);
        chk("postrst_tag_empty", dut.u_tag_fifo.empty, 1);
        chk("postrst_err", err_F, 0);
        chk("postrst_ch0_stall", ch0_stall, 1);
        nxt();

        // Result beat with nothing pending: sticky error, owner reported as 0.
        core_out_push = 1'b1;
        core_out_real = 16'h5555;
        nxt();
        core_out_push = 1'b0;
        chk("orphan_err", err_F, 1);
        chk("orphan_push", out_push_F, 1);
        chk("orphan_chan", out_chan_F, 0);
        nxt();
        chk("orphan_err_sticky", err_F, 1);

        // Abandoned frame leaves no residue: a fresh full frame feeds normally.
        ch1_push = 1'b1;
        run_frame(1'b1, -1);
        ch1_push = 1'b0;
        @(negedge clk);
        chk("final_tag_occ", dut.u_tag_fifo.count, 1);
        chk("final_err_sticky", err_F, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
